alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Registered, multi-cycle successor to the combinational ALU control decoder.
- Accepts a 7-bit funct (type[6:5], code[4:0]) plus shift amount through a valid/ready handshake and drives ALU control every cycle.
- Serialises shifts into 1-bit ALU steps with operand feedback; flags illegal encodings.
- Sits between the decode stage and the ALU in the multi-cycle datapath.

Parameters:
- CTRL_W, 3, ALU control width (>=3); encodings are zero-extended.
- SHAMT_W, 5, shift-amount width; maximum shift 2^SHAMT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns to IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- funct  in  7  [6:5] type, [4:0] code.
- shamt  in  SHAMT_W  shift amount, used only for shift ops.
- alu_ctrl  out  CTRL_W  ALU operation.
- alu_en  out  1  ALU result is to be written this cycle.
- fb_sel  out  1  0 = operand A from register file; 1 = previous ALU result.
- bypass  out  1  pass operand A unchanged (zero-length shift).
- illegal  out  1  unlisted funct.
- op_done  out  1  final cycle of the current op.
- busy  out  1  state != IDLE.

Behaviour:
- Decode table (ctrl):
  - Type 00: 0 AND=000, 1 ADD=001, 2 SUB=010, 3 CMP=011.
  - Type 01: 0 ANDI=000, 1 ADDI=001, 2 LW=001, 3 SW=001, 4 BEQ=011.
  - Type 10: 0 J=000, 1 JAL=001; alu_en=0.
  - Type 11: 0 SLL=100, 1 SLR=101.
  - Any other code: illegal.
- States: IDLE, ISSUE, SHIFT.
- Accept at edge T; outputs are registered and valid from T+1. No combinational path from funct to outputs.
- IDLE: in_ready=1; all other outputs 0.
- ISSUE lasts 1 cycle and is entered for:
  - non-shift ops;
  - illegal ops: illegal=1, alu_en=0, ctrl=0;
  - shifts with shamt<=1. shamt==0 gives bypass=1, alu_en=0, ctrl=shift code. shamt==1 gives alu_en=1.
  - In ISSUE: op_done=1, fb_sel=0.
- SHIFT (shamt>=2):
  - Counter loaded with shamt.
  - One cycle per bit: alu_en=1, ctrl=100/101.
  - fb_sel=0 on the first step, 1 on all later steps.
  - Counter decrements each step; op_done=1 on the step where the counter equals 1. Total shamt cycles.
- in_ready = (state==IDLE) || op_done.
  - Accepting on the op_done cycle gives back-to-back issue with no bubble.
  - Otherwise the block returns to IDLE.
- in_valid while busy and not op_done: not accepted; the request must be held.
- flush:
  - Takes priority over everything: next state IDLE, all outputs 0 next cycle.
  - A request presented in the same cycle is dropped, and in_ready is forced 0 while flush=1.
- Reset mid-operation: immediate return to IDLE. Outputs reset to in_ready=1, everything else 0, counter 0.
- shamt=2^SHAMT_W-1: counter must not wrap; exactly 2^SHAMT_W-1 steps.

Optional Feature:
- Macro: ALU_SEQ_BARREL_EN.
- Defined: every shift with shamt>=1 completes in ISSUE (1 cycle, alu_en=1, fb_sel=0); the ALU barrel shifter consumes shamt. shamt==0 still uses bypass. SHIFT state and counter are not built.
- Undefined: serial behaviour as specified above.

Decomposition:
- Package alu_seq_pkg:
  - type encodings (R=00, I=01, J=10, S=11);
  - ALU ctrl constants (AND, ADD, SUB, CMP, SL, SR);
  - state encoding.
- Sub-module alu_funct_decode: purely combinational (funct -> ctrl, is_shift, writes_alu, illegal), instantiated once.

Test Plan:
- Reset, then R-type ADD (funct=0000001): T+1 alu_ctrl=001, alu_en=1, op_done=1; T+2 IDLE, in_ready=1.
- SLL funct=1100000, shamt=3: 3 cycles ctrl=100, alu_en=1, fb_sel=0,1,1; op_done only on the 3rd.
- SLR shamt=5 with a second request (BEQ 0100100) held valid: BEQ is accepted on the op_done cycle; the next cycle shows ctrl=011, op_done=1, with no bubble.
- funct=0011111 and funct=1100010: illegal=1, alu_en=0, ctrl=000 for one cycle.
- SLL shamt=0 -> bypass=1, alu_en=0, op_done=1. SLL shamt=31 -> exactly 31 steps.
- flush in step 2 of a shamt=6 shift, and separately rst_n low mid-shift: next cycle IDLE, outputs 0, in_ready=1. Repeat with ALU_SEQ_BARREL_EN defined: shamt=6 completes in 1 cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer and its funct decoder.
package alu_seq_pkg;

  localparam int unsigned FUNCT_W     = 7;
  localparam int unsigned BASE_CTRL_W = 3;

  // Instruction type field, funct[6:5]
  typedef enum logic [1:0] {
    TYPE_R = 2'b00,
    TYPE_I = 2'b01,
    TYPE_J = 2'b10,
    TYPE_S = 2'b11
  } funct_type_e;

  // Request funct split into type and code
  typedef struct packed {
    funct_type_e ftype;
    logic [4:0]  code;
  } funct_t;

  // Native ALU control encodings, zero-extended to CTRL_W at the use site
  localparam logic [BASE_CTRL_W-1:0] CTRL_AND = 3'b000;
  localparam logic [BASE_CTRL_W-1:0] CTRL_ADD = 3'b001;
  localparam logic [BASE_CTRL_W-1:0] CTRL_SUB = 3'b010;
  localparam logic [BASE_CTRL_W-1:0] CTRL_CMP = 3'b011;
  localparam logic [BASE_CTRL_W-1:0] CTRL_SL  = 3'b100;
  localparam logic [BASE_CTRL_W-1:0] CTRL_SR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_SHIFT = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request handshake from decode plus the per-cycle ALU control bundle.
interface alu_op_sequencer_if #(
  parameter int unsigned CTRL_W  = 3,
  parameter int unsigned SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               alu_en;
  logic               fb_sel;
  logic               bypass;
  logic               illegal;
  logic               op_done;
  logic               busy;

  // Decode-stage side
  modport master (
    output in_valid, funct, shamt,
    input  in_ready, alu_ctrl, alu_en, fb_sel, bypass, illegal, op_done, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid, funct, shamt,
    output in_ready, alu_ctrl, alu_en, fb_sel, bypass, illegal, op_done, busy
  );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational funct decoder: ALU control, shift/write classification, illegal flag.
module alu_funct_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned CTRL_W = 3
) (
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               is_shift,
  output logic               writes_alu,
  output logic               illegal
);

  funct_t                 f;
  logic [BASE_CTRL_W-1:0] base_ctrl;

  assign f    = funct_t'(funct);
  assign ctrl = CTRL_W'(base_ctrl);

  // Decode table; unlisted codes fall through to illegal with ctrl=AND(000)
  always_comb begin
    base_ctrl  = CTRL_AND;
    is_shift   = 1'b0;
    writes_alu = 1'b0;
    illegal    = 1'b0;
    case (f.ftype)
      TYPE_R: begin
        writes_alu = 1'b1;
        case (f.code)
          5'd0:    base_ctrl = CTRL_AND;
          5'd1:    base_ctrl = CTRL_ADD;
          5'd2:    base_ctrl = CTRL_SUB;
          5'd3:    base_ctrl = CTRL_CMP;
          default: begin illegal = 1'b1; writes_alu = 1'b0; end
        endcase
      end
      TYPE_I: begin
        writes_alu = 1'b1;
        case (f.code)
          5'd0:    base_ctrl = CTRL_AND;
          5'd1:    base_ctrl = CTRL_ADD;
          5'd2:    base_ctrl = CTRL_ADD;
          5'd3:    base_ctrl = CTRL_ADD;
          5'd4:    base_ctrl = CTRL_CMP;
          default: begin illegal = 1'b1; writes_alu = 1'b0; end
        endcase
      end
      TYPE_J: begin
        // Jumps drive ctrl but never write an ALU result
        case (f.code)
          5'd0:    base_ctrl = CTRL_AND;
          5'd1:    base_ctrl = CTRL_ADD;
          default: illegal = 1'b1;
        endcase
      end
      TYPE_S: begin
        writes_alu = 1'b1;
        is_shift   = 1'b1;
        case (f.code)
          5'd0:    base_ctrl = CTRL_SL;
          5'd1:    base_ctrl = CTRL_SR;
          default: begin illegal = 1'b1; writes_alu = 1'b0; is_shift = 1'b0; end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered multi-cycle ALU control sequencer.
// Shifts are serialised into 1-bit ALU steps with result feedback unless
// ALU_SEQ_BARREL_EN is defined, in which case every shift issues in one cycle.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned CTRL_W  = 3,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_op_sequencer_if.slave   bus
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_is_shift;
  logic              dec_writes_alu;
  logic              dec_illegal;

  seq_state_e        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              en_q, en_d;
  logic              fb_q, fb_d;
  logic              byp_q, byp_d;
  logic              ill_q, ill_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              accept_c;
  logic              zero_shamt_c;
`ifndef ALU_SEQ_BARREL_EN
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
`endif

  alu_funct_decode #(.CTRL_W(CTRL_W)) u_decode (
    .funct      (bus.funct),
    .ctrl       (dec_ctrl),
    .is_shift   (dec_is_shift),
    .writes_alu (dec_writes_alu),
    .illegal    (dec_illegal)
  );

  // flush masks readiness so a coincident request is dropped
  assign bus.in_ready = rdy_q && !flush;
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign zero_shamt_c = (bus.shamt == '0);

  assign bus.alu_ctrl = ctrl_q;
  assign bus.alu_en   = en_q;
  assign bus.fb_sel   = fb_q;
  assign bus.bypass   = byp_q;
  assign bus.illegal  = ill_q;
  assign bus.op_done  = done_q;
  assign bus.busy     = busy_q;

  // Next state and next registered outputs
  always_comb begin
    state_d = ST_IDLE;
    ctrl_d  = '0;
    en_d    = 1'b0;
    fb_d    = 1'b0;
    byp_d   = 1'b0;
    ill_d   = 1'b0;
    done_d  = 1'b0;
`ifndef ALU_SEQ_BARREL_EN
    cnt_d   = cnt_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
`ifndef ALU_SEQ_BARREL_EN
      cnt_d   = '0;
`endif
    end else if (accept_c) begin
      if (dec_illegal) begin
        state_d = ST_ISSUE;
        ill_d   = 1'b1;
        done_d  = 1'b1;
`ifndef ALU_SEQ_BARREL_EN
      end else if (dec_is_shift && (bus.shamt > SHAMT_W'(1))) begin
        // First serial step operates on the register-file operand
        state_d = ST_SHIFT;
        cnt_d   = bus.shamt;
        ctrl_d  = dec_ctrl;
        en_d    = 1'b1;
`endif
      end else begin
        state_d = ST_ISSUE;
        ctrl_d  = dec_ctrl;
        byp_d   = dec_is_shift && zero_shamt_c;
        en_d    = dec_writes_alu && !(dec_is_shift && zero_shamt_c);
        done_d  = 1'b1;
      end
`ifndef ALU_SEQ_BARREL_EN
    end else if ((state_q == ST_SHIFT) && !done_q) begin
      // Later steps feed back the previous ALU result; last step at count 1
      state_d = ST_SHIFT;
      cnt_d   = cnt_q - SHAMT_W'(1);
      ctrl_d  = ctrl_q;
      en_d    = 1'b1;
      fb_d    = 1'b1;
      done_d  = (cnt_q == SHAMT_W'(2));
`endif
    end
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE) || done_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      en_q    <= 1'b0;
      fb_q    <= 1'b0;
      byp_q   <= 1'b0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
`ifndef ALU_SEQ_BARREL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      en_q    <= en_d;
      fb_q    <= fb_d;
      byp_q   <= byp_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
`ifndef ALU_SEQ_BARREL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed table-driven bench for alu_op_sequencer (serial or ALU_SEQ_BARREL_EN build).
module tb_alu_op_sequencer;

  typedef struct packed {
    logic       rdy;
    logic [2:0] ctrl;
    logic       en;
    logic       fb;
    logic       byp;
    logic       ill;
    logic       done;
    logic       busy;
  } obs_t;

  typedef struct {
    logic       v;
    logic [6:0] funct;
    logic [4:0] shamt;
    logic       fl;
    obs_t       exp;
    string      name;
  } vec_t;

  localparam logic [6:0] F_ADD  = 7'b0000001;
  localparam logic [6:0] F_SUB  = 7'b0000010;
  localparam logic [6:0] F_SLL  = 7'b1100000;
  localparam logic [6:0] F_SLR  = 7'b1100001;
  localparam logic [6:0] F_BEQ  = 7'b0100100;
  localparam logic [6:0] F_JAL  = 7'b1000001;
  localparam logic [6:0] F_BAD0 = 7'b0011111;
  localparam logic [6:0] F_BAD1 = 7'b1100010;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];

  alu_op_sequencer_if #(.CTRL_W(3), .SHAMT_W(5)) bus ();

  alu_op_sequencer #(.CTRL_W(3), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic rdy, input logic [2:0] ctrl, input logic en,
                              input logic fb, input logic byp, input logic ill,
                              input logic done, input logic busy);
    obs_t o;
    o.rdy = rdy; o.ctrl = ctrl; o.en = en; o.fb = fb;
    o.byp = byp; o.ill = ill; o.done = done; o.busy = busy;
    return o;
  endfunction

  function automatic obs_t idle_o();
    return mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic add(input string name, input logic v, input logic [6:0] funct,
                     input logic [4:0] shamt, input logic fl, input obs_t e);
    vec_t r;
    r.name = name; r.v = v; r.funct = funct; r.shamt = shamt; r.fl = fl; r.exp = e;
    tbl.push_back(r);
  endtask

  // Accept a shift from idle, expect its full step sequence, then idle
  task automatic add_shift(input string name, input logic [6:0] funct,
                           input logic [2:0] ctrl, input int shamt);
    add({name, "_acc"}, 1'b1, funct, 5'(shamt), 1'b0, idle_o());
`ifdef ALU_SEQ_BARREL_EN
    add({name, "_issue"}, 1'b0, 7'd0, 5'd0, 1'b0,
        mk(1'b1, ctrl, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
`else
    for (int k = 1; k <= shamt; k++) begin
      add($sformatf("%s_step%0d", name, k), 1'b0, 7'd0, 5'd0, 1'b0,
          mk(k == shamt, ctrl, 1'b1, k > 1, 1'b0, 1'b0, k == shamt, 1'b1));
    end
`endif
    add({name, "_idle"}, 1'b0, 7'd0, 5'd0, 1'b0, idle_o());
  endtask

  function automatic obs_t sample();
    return mk(bus.in_ready, bus.alu_ctrl, bus.alu_en, bus.fb_sel, bus.bypass,
              bus.illegal, bus.op_done, bus.busy);
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b ctrl=%b en=%b fb=%b byp=%b ill=%b done=%b busy=%b, expected rdy=%b ctrl=%b en=%b fb=%b byp=%b ill=%b done=%b busy=%b",
               name, got.rdy, got.ctrl, got.en, got.fb, got.byp, got.ill, got.done, got.busy,
               exp.rdy, exp.ctrl, exp.en, exp.fb, exp.byp, exp.ill, exp.done, exp.busy);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] funct, input logic [4:0] shamt,
                       input logic fl);
    bus.in_valid = v;
    bus.funct    = funct;
    bus.shamt    = shamt;
    flush        = fl;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 1'b0);

    // Reset state and a single R-type ADD
    add("reset", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());
    add("add_acc", 1'b1, F_ADD, 5'd0, 1'b0, idle_o());
    add("add_issue", 1'b0, 7'd0, 5'd0, 1'b0, mk(1, 3'b001, 1, 0, 0, 0, 1, 1));
    add("add_idle", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());

    add_shift("sll3", F_SLL, 3'b100, 3);

    // SLR shamt=5 with BEQ held until the op_done cycle
    add("slr5_acc", 1'b1, F_SLR, 5'd5, 1'b0, idle_o());
`ifdef ALU_SEQ_BARREL_EN
    add("slr5_issue", 1'b1, F_BEQ, 5'd0, 1'b0, mk(1, 3'b101, 1, 0, 0, 0, 1, 1));
`else
    add("slr5_s1", 1'b1, F_BEQ, 5'd0, 1'b0, mk(0, 3'b101, 1, 0, 0, 0, 0, 1));
    add("slr5_s2", 1'b1, F_BEQ, 5'd0, 1'b0, mk(0, 3'b101, 1, 1, 0, 0, 0, 1));
    add("slr5_s3", 1'b1, F_BEQ, 5'd0, 1'b0, mk(0, 3'b101, 1, 1, 0, 0, 0, 1));
    add("slr5_s4", 1'b1, F_BEQ, 5'd0, 1'b0, mk(0, 3'b101, 1, 1, 0, 0, 0, 1));
    add("slr5_s5", 1'b1, F_BEQ, 5'd0, 1'b0, mk(1, 3'b101, 1, 1, 0, 0, 1, 1));
`endif
    add("beq_issue", 1'b0, 7'd0, 5'd0, 1'b0, mk(1, 3'b011, 1, 0, 0, 0, 1, 1));
    add("beq_idle", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());

    // Back-to-back illegal encodings
    add("ill0_acc", 1'b1, F_BAD0, 5'd0, 1'b0, idle_o());
    add("ill0_issue", 1'b1, F_BAD1, 5'd3, 1'b0, mk(1, 3'b000, 0, 0, 0, 1, 1, 1));
    add("ill1_issue", 1'b0, 7'd0, 5'd0, 1'b0, mk(1, 3'b000, 0, 0, 0, 1, 1, 1));
    add("ill_idle", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());

    // Zero-length shift bypasses, SLL shamt=1 is a single write
    add("sll0_acc", 1'b1, F_SLL, 5'd0, 1'b0, idle_o());
    add("sll0_issue", 1'b0, 7'd0, 5'd0, 1'b0, mk(1, 3'b100, 0, 0, 1, 0, 1, 1));
    add("sll0_idle", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());
    add("sll1_acc", 1'b1, F_SLL, 5'd1, 1'b0, idle_o());
    add("sll1_issue", 1'b0, 7'd0, 5'd0, 1'b0, mk(1, 3'b100, 1, 0, 0, 0, 1, 1));
    add("sll1_idle", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());

    // JAL never writes; SUB ignores shamt
    add("jal_acc", 1'b1, F_JAL, 5'd0, 1'b0, idle_o());
    add("jal_issue", 1'b1, F_SUB, 5'd7, 1'b0, mk(1, 3'b001, 0, 0, 0, 0, 1, 1));
    add("sub_issue", 1'b0, 7'd0, 5'd0, 1'b0, mk(1, 3'b010, 1, 0, 0, 0, 1, 1));
    add("sub_idle", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());

    // Maximum shift amount
    add_shift("sll31", F_SLL, 3'b100, 31);

    // flush during step 2 of a shamt=6 shift (single issue in barrel build)
`ifdef ALU_SEQ_BARREL_EN
    add_shift("sll6", F_SLL, 3'b100, 6);
`else
    add("fl6_acc", 1'b1, F_SLL, 5'd6, 1'b0, idle_o());
    add("fl6_s1", 1'b0, 7'd0, 5'd0, 1'b0, mk(0, 3'b100, 1, 0, 0, 0, 0, 1));
    add("fl6_s2", 1'b1, F_ADD, 5'd0, 1'b1, mk(0, 3'b100, 1, 1, 0, 0, 0, 1));
    add("fl6_idle", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());
`endif
    // flush while idle drops a coincident request and masks in_ready
    add("flidle_req", 1'b1, F_ADD, 5'd0, 1'b1, mk(0, 3'b000, 0, 0, 0, 0, 0, 0));
    add("flidle_after", 1'b0, 7'd0, 5'd0, 1'b0, idle_o());

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].funct, tbl[i].shamt, tbl[i].fl);
      #1;
      chk(tbl[i].name, sample(), tbl[i].exp);
    end

    // Asynchronous reset during an active op
    @(negedge clk);
    drive(1'b1, F_SLL, 5'd6, 1'b0);
    @(negedge clk);
    drive(1'b0, 7'd0, 5'd0, 1'b0);
    #1;
    chk("rst_mid_active", sample(),
`ifdef ALU_SEQ_BARREL_EN
        mk(1, 3'b100, 1, 0, 0, 0, 1, 1));
`else
        mk(0, 3'b100, 1, 0, 0, 0, 0, 1));
`endif
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", sample(), idle_o());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release", sample(), idle_o());
    @(negedge clk);
    #1;
    chk("rst_stay_idle", sample(), idle_o());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
